// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Index width that stays at least 1 bit even for a degenerate count of 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant,
// wrapping modulo NUM_REQ.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // cand[k] is the requester examined k+1 places after the previous owner.
  logic [IDX_W-1:0] cand [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign cand[k] = IDX_W'((int'(last_grant) + k + 1) % NUM_REQ);
  end

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler with burst locking: one producer owns the
// FIFO write port for up to MAX_BURST accepted words, throttled by w_full.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            w_clk,
  input  logic                            w_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            w_full,
  output logic                            w_inc,
  output logic [DATA_WIDTH-1:0]           w_data,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            busy
);

  localparam int GID_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [GID_W-1:0] GID_LAST = GID_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_found;
  logic [GID_W-1:0] pick_idx;
  logic             burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Write-port muxing is combinational so w_full throttles in the same cycle.
  always_comb begin
    req_ready = '0;
    w_inc     = 1'b0;
    w_data    = '0;
    if (state_q == ST_BURST) begin
      req_ready[grant_q] = ~w_full;
      w_inc              = req_valid[grant_q] & ~w_full;
      w_data             = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Last flag and beat limit coinciding still form a single burst end.
  assign burst_end = w_inc & (req_last[grant_q] | (burst_cnt_q == CNT_LAST));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_inc) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if (burst_end) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GID_LAST;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4). Inputs change 1 ns after the rising edge; outputs sampled on the falling edge.
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        w_full;
  logic        w_inc;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_inc     (w_inc),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 w_clk = ~w_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic set_word(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  // Sample at the falling edge, then advance to 1 ns after the next rising edge.
  task automatic cyc(input string nm, input logic eb, input logic ei,
                     input logic [1:0] eg, input logic [3:0] er, input logic [7:0] ed);
    @(negedge w_clk);
    n_cmp++;
    if (busy !== eb) begin
      n_err++;
      $display("FAIL %s busy: got %b want %b", nm, busy, eb);
    end
    n_cmp++;
    if (w_inc !== ei) begin
      n_err++;
      $display("FAIL %s w_inc: got %b want %b", nm, w_inc, ei);
    end
    n_cmp++;
    if (req_ready !== er) begin
      n_err++;
      $display("FAIL %s req_ready: got %b want %b", nm, req_ready, er);
    end
    if (eb) begin
      n_cmp++;
      if (grant_id !== eg) begin
        n_err++;
        $display("FAIL %s grant_id: got %0d want %0d", nm, grant_id, eg);
      end
    end
    if (ei || !eb) begin
      n_cmp++;
      if (w_data !== ed) begin
        n_err++;
        $display("FAIL %s w_data: got %h want %h", nm, w_data, ed);
      end
    end
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    w_full    = 1'b0;
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    w_rst_n   = 1'b0;
    req_valid = 4'b1111;
    req_last  = '0;
    req_data  = 32'h3020_1000;
    w_full    = 1'b0;
    cyc("rst_hold", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    @(negedge w_clk);
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL rst_grant_id: got %0d want 0", grant_id);
    end
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    cyc("first_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    for (int b = 0; b < 4; b++) begin
      set_word(0, 8'h00 + 8'(b));
      cyc("first_beat", 1'b1, 1'b1, 2'd0, 4'b0001, 8'h00 + 8'(b));
    end
    cyc("first_gap", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    set_word(1, 8'h10);
    cyc("second_grant", 1'b1, 1'b1, 2'd1, 4'b0010, 8'h10);
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hA3A2_A1A0;
    for (int k = 0; k < 5; k++) begin
      cyc("rr_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
      cyc("rr_beat", 1'b1, 1'b1, 2'(k % 4), 4'(1 << (k % 4)), 8'hA0 + 8'(k % 4));
    end
    req_valid = '0;
    cyc("rr_drain", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0100;
    cyc("bp_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    for (int b = 0; b < 2; b++) begin
      set_word(2, 8'h20 + 8'(b));
      cyc("bp_beat_pre", 1'b1, 1'b1, 2'd2, 4'b0100, 8'h20 + 8'(b));
    end
    set_word(2, 8'h22);
    w_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc("bp_full", 1'b1, 1'b0, 2'd2, 4'b0000, 8'h00);
    end
    w_full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      set_word(2, 8'h20 + 8'(b));
      cyc("bp_beat_post", 1'b1, 1'b1, 2'd2, 4'b0100, 8'h20 + 8'(b));
    end
    req_valid = '0;
    cyc("bp_end", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 4'b1010;
    set_word(1, 8'h10);
    set_word(3, 8'h30);
    cyc("lock_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    cyc("lock_beat0", 1'b1, 1'b1, 2'd1, 4'b0010, 8'h10);
    req_valid = 4'b1000;
    cyc("lock_gap", 1'b1, 1'b0, 2'd1, 4'b0010, 8'h00);
    cyc("lock_gap", 1'b1, 1'b0, 2'd1, 4'b0010, 8'h00);
    req_valid = 4'b1010;
    req_last  = 4'b0010;
    set_word(1, 8'h11);
    cyc("lock_last", 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11);
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    cyc("lock_idle2", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    cyc("lock_next", 1'b1, 1'b1, 2'd3, 4'b1000, 8'h30);
    req_valid = '0;
    req_last  = '0;
    cyc("lock_end", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
  endtask

  task automatic test_limit_and_full();
    do_reset();
    req_valid = 4'b0001;
    cyc("lim_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    for (int b = 0; b < 4; b++) begin
      set_word(0, 8'h40 + 8'(b));
      req_last = (b == 3) ? 4'b0001 : 4'b0000;
      cyc("lim_beat", 1'b1, 1'b1, 2'd0, 4'b0001, 8'h40 + 8'(b));
    end
    req_last = 4'b0001;
    set_word(0, 8'h50);
    cyc("lim_gap", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    w_full = 1'b1;
    cyc("full_on_last", 1'b1, 1'b0, 2'd0, 4'b0000, 8'h00);
    w_full = 1'b0;
    cyc("last_accept", 1'b1, 1'b1, 2'd0, 4'b0001, 8'h50);
    req_valid = '0;
    req_last  = '0;
    cyc("lim_end", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h3020_1060;
    cyc("ar_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    cyc("ar_beat0", 1'b1, 1'b1, 2'd0, 4'b0001, 8'h60);
    set_word(0, 8'h61);
    @(negedge w_clk);
    n_cmp++;
    if (w_inc !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ar_beat1 inc/busy: got %b%b want 11", w_inc, busy);
    end
    #2;
    w_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({w_inc, busy, req_ready} !== 6'b000000) begin
      n_err++;
      $display("FAIL ar_drop inc/busy/ready: got %b%b%b want 000000", w_inc, busy, req_ready);
    end
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    set_word(0, 8'h70);
    cyc("ar_post_idle", 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
    cyc("ar_post_grant", 1'b1, 1'b1, 2'd0, 4'b0001, 8'h70);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_limit_and_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port among `NUM_REQ` producers in the write clock domain, using round-robin arbitration with burst locking. It drives the write-increment and write-data inputs of the write-pointer logic and throttles every producer on the write-full flag. It sits between the producers and the FIFO write port, entirely in the write domain.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum beats per grant (≥1).
- `w_clk`  in  1  write-domain clock.
- `w_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  final word of requester's burst.
- `req_ready`  out  NUM_REQ  word accepted when valid & ready.
- `w_full`  in  1  FIFO full flag from the write-full logic.
- `w_inc`  out  1  write strobe to the FIFO write port.
- `w_data`  out  DATA_WIDTH  word to the FIFO write port.
- `grant_id`  out  clog2(NUM_REQ)  current owner; valid while `busy`.
- `busy`  out  1  a burst is in progress.

## Operation
- FSM states: IDLE, BURST. Registers: state, `grant_id`, `last_grant`, `burst_cnt` (clog2(MAX_BURST+1) bits).
- **IDLE**
  - If any `req_valid` is high, pick the first asserted index searching from `last_grant+1` modulo NUM_REQ.
  - Register the pick into `grant_id`, clear `burst_cnt`, and go to BURST.
  - No `req_ready` is asserted in IDLE.
- **BURST**
  - `req_ready[grant_id] = ~w_full`. All other `req_ready` bits are 0.
  - `w_inc = req_valid[grant_id] & ~w_full`.
  - `w_data = req_data[grant_id]`. It is a don't-care when `w_inc`=0 and is driven 0 in IDLE.
  - On each accepted beat (`w_inc`=1), `burst_cnt` increments.
  - The burst ends on an accepted beat with `req_last[grant_id]`=1, or on an accepted beat with `burst_cnt==MAX_BURST-1`.
  - At burst end: `last_grant<=grant_id`, state goes to IDLE.
- **Lock:** the owner keeps the grant while its `req_valid` is low mid-burst. Other requesters wait.
- **`w_full` high in BURST:** no acceptance and no counter change; state holds.
- **Simultaneous events:** `req_last` together with the MAX_BURST limit on the same beat is a single end-of-burst. A `req_last` beat blocked by `w_full` does not end the burst.
- **`busy`** = (state==BURST).
- **Reset values:** state IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `grant_id`=0, `burst_cnt`=0, `busy`=0, `w_inc`=0, `req_ready`=0, `w_data`=0.
- **Reset mid-burst:** the FSM returns to IDLE immediately. A partial burst already in the FIFO is not rolled back.

## Timing
- Arbitration latency is 1 cycle: valid seen in IDLE at edge N gives ready in cycle N+1.
- `w_inc`, `req_ready` and `w_data` are combinational from registered state plus `req_valid`/`w_full`/`req_data`, within the same cycle.
- `w_full` is honoured in the same cycle. No word is strobed while `w_full`=1.
- One IDLE cycle separates consecutive bursts. Peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle.
- `grant_id` is stable for the whole burst.

## Structure
- Package `fifo_wr_arb_pkg`:
  - state enum (IDLE, BURST);
  - a `clog2`-based width constant helper for `grant_id` and `burst_cnt`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are `found` and the index. It is instantiated once.
- FSM, counters and output muxing live in the top module.

## Test plan
- **Reset/first grant:** reset, then `req_valid`=4'b1111, no `req_last`, `w_full`=0. Expect `grant_id`=0; 4 beats accepted on cycles 2–5 after reset release; IDLE; then `grant_id`=1.
- **Round-robin rotation:** all four requesters each send a 1-word burst (`req_last`=1). Expect grant order 0,1,2,3,0 with each `w_inc` two cycles apart.
- **Full backpressure:**
  - During requester 2's burst, hold `w_full`=1 for 3 cycles.
  - Expect `w_inc`=0, `req_ready[2]`=0 and `burst_cnt` frozen.
  - On release, beats resume with data in order and no loss or duplicates.
- **Early last and lock:**
  - Requester 1 drops `req_valid` for 2 cycles mid-burst; requester 3 is valid throughout.
  - Expect the grant to stay on 1.
  - `req_last` on beat 2 ends the burst, then 3 is granted.
- **Last on limit / full on last:**
  - `req_last` on beat 4 (MAX_BURST=4) gives a single IDLE transition.
  - `req_last` presented while `w_full`=1 keeps BURST until the beat is accepted.
- **Async reset mid-burst:** assert `w_rst_n`=0 between edges during beat 2. Expect `w_inc`, `busy` and `req_ready` to drop to 0 immediately, and the first post-reset grant to go to requester 0.
